serial_adder_ctrl: RTL



---
 rtl/serial_adder_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: WIDTH-bit a + b + c_in through one shared full-adder cell, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module FullAdder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,output logic             ovf
`endif
);
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [WIDTH-2:0]   psum_q, psum_d;
   logic [WIDTH-1:0]   psum_next;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               c_out_q, c_out_d;
   logic               fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   FullAdder u_fa (
      .a_i (a_q[0]),
      .b_i (b_q[0]),
      .c_i (carry_q),
      .s_o (fa_s),
      .c_o (fa_co)
   );

   // Partial sum keeps only the WIDTH-1 settled bits; the current cell output completes it.
   assign psum_next = {fa_s, psum_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      psum_d  = psum_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = c_in;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            psum_d  = psum_next[WIDTH-1:1];
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               sum_d   = psum_next;
               c_out_d = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q is the carry into the MSB during the final bit
               ovf_d   = carry_q ^ fa_co;
`endif
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         psum_q  <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         psum_q  <= psum_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);
   assign sum   = sum_q;
   assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule
